// File: rtl/dstar_frame_tx.sv
// Serial framer: 64-bit word -> 10 bytes (A5 header, 8 payload bytes LSB first, XOR checksum),
// each byte 8N1 at CLKS_PER_BIT clocks per bit, followed by GAP_BITS idle-high bit times.
module dstar_frame_tx #(
  parameter int CLKS_PER_BIT = 4,
  parameter int GAP_BITS     = 2
) (
  input  logic        I_clk,
  input  logic        I_Rst,
  input  logic [63:0] I_data,
  input  logic        I_data_valid,
  output logic        O_tx_ready,
  output logic        O_txb,
  output logic        O_frame_done
);

  localparam int          CW       = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [3:0]  GAP_LAST = (GAP_BITS > 0) ? 4'(GAP_BITS - 1) : 4'd0;

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP, S_GAP} state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] clk_cnt_q, clk_cnt_d;
  logic [3:0]    bit_q, bit_d;
  logic [3:0]    byte_q, byte_d;
  logic [63:0]   data_q, data_d;
  logic [7:0]    csum_q, csum_d;
  logic          txb_q, txb_d;
  logic          rdy_q, rdy_d;
  logic          done_q, done_d;

  logic          accept, bit_end, last_byte;
  logic [7:0]    in_xor, cur_byte;
  logic [2:0]    pay_sel;

  assign accept    = (state_q == S_IDLE) && rdy_q && I_data_valid;
  assign bit_end   = (clk_cnt_q == CNT_LAST);
  assign last_byte = (byte_q == 4'd9);

  always_comb begin
    in_xor = '0;
    for (int i = 0; i < 8; i++) in_xor = in_xor ^ I_data[8*i +: 8];
  end

  // State register
  always_ff @(posedge I_clk or posedge I_Rst) begin
    if (I_Rst) begin
      state_q   <= S_IDLE;
      clk_cnt_q <= '0;
      bit_q     <= '0;
      byte_q    <= '0;
    end else begin
      state_q   <= state_d;
      clk_cnt_q <= clk_cnt_d;
      bit_q     <= bit_d;
      byte_q    <= byte_d;
    end
  end

  // Next state and counters
  always_comb begin
    state_d   = state_q;
    clk_cnt_d = clk_cnt_q;
    bit_d     = bit_q;
    byte_d    = byte_q;
    case (state_q)
      S_IDLE:  if (accept) state_d = S_START;
      S_START: if (bit_end) state_d = S_DATA;
      S_DATA:  if (bit_end && bit_q == 4'd7) state_d = S_STOP;
      S_STOP: begin
        if (bit_end) begin
          if (last_byte) begin
            state_d = (GAP_BITS == 0) ? S_IDLE : S_GAP;
          end else begin
            state_d = S_START;
            byte_d  = byte_q + 4'd1;
          end
        end
      end
      S_GAP:   if (bit_end && bit_q == GAP_LAST) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (state_d != state_q) begin
      clk_cnt_d = '0;
      bit_d     = '0;
    end else if (state_q != S_IDLE) begin
      clk_cnt_d = bit_end ? '0 : clk_cnt_q + CW'(1);
      if (bit_end) bit_d = bit_q + 4'd1;
    end
    if (state_d == S_IDLE) byte_d = '0;
  end

  // Outputs: line level is computed for the state being entered so O_txb stays registered
  always_comb begin
    pay_sel  = 3'(byte_d - 4'd1);
    case (byte_d)
      4'd0:    cur_byte = 8'hA5;
      4'd9:    cur_byte = csum_q;
      default: cur_byte = data_q[{pay_sel, 3'b000} +: 8];
    endcase
    case (state_d)
      S_START: txb_d = 1'b0;
      S_DATA:  txb_d = cur_byte[bit_d[2:0]];
      default: txb_d = 1'b1;
    endcase
    rdy_d  = (state_d == S_IDLE);
    done_d = (state_q == S_STOP) && bit_end && last_byte;
    data_d = accept ? I_data : data_q;
    csum_d = accept ? in_xor : csum_q;
  end

  always_ff @(posedge I_clk or posedge I_Rst) begin
    if (I_Rst) begin
      data_q <= '0;
      csum_q <= '0;
      txb_q  <= 1'b1;
      rdy_q  <= 1'b0;
      done_q <= 1'b0;
    end else begin
      data_q <= data_d;
      csum_q <= csum_d;
      txb_q  <= txb_d;
      rdy_q  <= rdy_d;
      done_q <= done_d;
    end
  end

  assign O_txb        = txb_q;
  assign O_tx_ready   = rdy_q;
  assign O_frame_done = done_q;

endmodule

// File: tb/tb_dstar_frame_tx.sv
// Bench for dstar_frame_tx: two instances (4 clk/bit + 2 gap bits, 2 clk/bit + no gap)
// checked every cycle against a time-since-acceptance model, plus literal frame checks.
module tb_dstar_frame_tx;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_a = 1'b1, rst_b = 1'b1;
  logic        vld_a = 1'b0, vld_b = 1'b0;
  logic [63:0] dat_a = '0, dat_b = '0;
  logic        txb_a, rdy_a, done_a, txb_b, rdy_b, done_b;

  dstar_frame_tx #(.CLKS_PER_BIT(4), .GAP_BITS(2)) dut_a (
    .I_clk(clk), .I_Rst(rst_a), .I_data(dat_a), .I_data_valid(vld_a),
    .O_tx_ready(rdy_a), .O_txb(txb_a), .O_frame_done(done_a));

  dstar_frame_tx #(.CLKS_PER_BIT(2), .GAP_BITS(0)) dut_b (
    .I_clk(clk), .I_Rst(rst_b), .I_data(dat_b), .I_data_valid(vld_b),
    .O_tx_ready(rdy_b), .O_txb(txb_b), .O_frame_done(done_b));

  int checks = 0, errors = 0;

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (errors <= 40) $display("FAIL %s got=%0h want=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic fail_now(string nm);
    checks++;
    errors++;
    $display("FAIL %s got=timeout want=event t=%0t", nm, $time);
  endtask

  function automatic int cpb_of(int i); return (i == 0) ? 4 : 2; endfunction
  function automatic int gap_of(int i); return (i == 0) ? 2 : 0; endfunction
  function automatic logic rdy_of(int i);  return (i == 0) ? rdy_a : rdy_b; endfunction
  function automatic logic txb_of(int i);  return (i == 0) ? txb_a : txb_b; endfunction
  function automatic logic done_of(int i); return (i == 0) ? done_a : done_b; endfunction

  task automatic drive(int i, logic v, logic [63:0] d);
    if (i == 0) begin vld_a = v; dat_a = d; end
    else        begin vld_b = v; dat_b = d; end
  endtask

  // ---------------- behavioural model ----------------
  function automatic logic [7:0] frame_byte(logic [63:0] w, int b);
    logic [7:0] x = '0;
    if (b == 0) return 8'hA5;
    if (b == 9) begin
      for (int k = 0; k < 8; k++) x = x ^ w[8*k +: 8];
      return x;
    end
    return w[8*(b-1) +: 8];
  endfunction

  // Bit k of the 100-bit frame (10 bits per byte: start, 8 data LSB first, stop)
  function automatic logic frame_bit(logic [63:0] w, int k);
    int pos = k % 10;
    logic [7:0] v = frame_byte(w, k / 10);
    if (pos == 0) return 1'b0;
    if (pos == 9) return 1'b1;
    return v[pos-1];
  endfunction

  logic        m_busy[2] = '{1'b0, 1'b0};
  logic        m_rdy[2]  = '{1'b0, 1'b0};
  logic        m_txb[2]  = '{1'b1, 1'b1};
  logic        m_done[2] = '{1'b0, 1'b0};
  int          m_t[2]    = '{0, 0};
  logic [63:0] m_w[2];

  task automatic model_step(int i, logic r, logic v, logic [63:0] d);
    int c = cpb_of(i);
    int g = gap_of(i);
    if (r) begin
      m_busy[i] = 1'b0; m_rdy[i] = 1'b0; m_txb[i] = 1'b1; m_done[i] = 1'b0;
      return;
    end
    m_done[i] = 1'b0;
    if (m_busy[i]) begin
      m_t[i]++;
      m_txb[i]  = (m_t[i] < 100*c) ? frame_bit(m_w[i], m_t[i] / c) : 1'b1;
      m_done[i] = (m_t[i] == 100*c);
      if (m_t[i] == (100+g)*c) begin m_busy[i] = 1'b0; m_rdy[i] = 1'b1; end
    end else if (m_rdy[i] && v) begin
      m_busy[i] = 1'b1; m_t[i] = 0; m_w[i] = d; m_rdy[i] = 1'b0; m_txb[i] = 1'b0;
    end else begin
      m_rdy[i] = 1'b1; m_txb[i] = 1'b1;
    end
  endtask

  always @(posedge clk or posedge rst_a) model_step(0, rst_a, vld_a, dat_a);
  always @(posedge clk or posedge rst_b) model_step(1, rst_b, vld_b, dat_b);

  always @(negedge clk) begin
    chk("txb_a",  txb_a,  m_txb[0]);
    chk("rdy_a",  rdy_a,  m_rdy[0]);
    chk("done_a", done_a, m_done[0]);
    chk("txb_b",  txb_b,  m_txb[1]);
    chk("rdy_b",  rdy_b,  m_rdy[1]);
    chk("done_b", done_b, m_done[1]);
  end

  // ---------------- directed tasks ----------------
  task automatic run_frame(int i, logic [63:0] w, logic [79:0] exp, int pulse_at, int rst_at,
                           output int done_at, output int rdy_at);
    int c = cpb_of(i);
    int g = gap_of(i);
    int k = 0;
    int len;
    logic ln[512];
    logic [7:0] got;
    done_at = -1;
    rdy_at  = -1;
    len = (100+g)*c + 2;
    @(negedge clk);
    while (!rdy_of(i) && k < 3000) begin @(negedge clk); k++; end
    if (!rdy_of(i)) begin fail_now("wait_ready"); return; end
    drive(i, 1'b1, w);
    for (int n = 0; n < len; n++) begin
      @(negedge clk);
      if (n == 0) drive(i, 1'b0, w);
      if (n == pulse_at) drive(i, 1'b1, '1);
      if (n == pulse_at + 1) drive(i, 1'b0, w);
      ln[n] = txb_of(i);
      if (done_of(i) && done_at < 0) done_at = n;
      if (rdy_of(i) && rdy_at < 0) rdy_at = n;
      if (n == rst_at) begin
        #2 rst_a = 1'b1;
        #1;
        chk("rst_txb_now", txb_a, 1'b1);
        chk("rst_rdy_now", rdy_a, 1'b0);
        repeat (3) begin @(negedge clk); chk("rst_no_done", done_a, 1'b0); end
        rst_a = 1'b0;
        @(posedge clk); #1;
        chk("rdy_after_release", rdy_a, 1'b1);
        return;
      end
    end
    for (int b = 0; b < 10; b++) begin
      for (int j = 0; j < 8; j++) got[j] = ln[(b*10 + 1 + j)*c + c/2];
      chk($sformatf("byte%0d_inst%0d", b, i), got, exp[79-8*b -: 8]);
    end
  endtask

  task automatic b2b(int i, logic [63:0] w1, logic [63:0] w2, output int per);
    int at1 = -1, at2 = -1, k = 0;
    logic prev;
    per = -1;
    @(negedge clk);
    while (!rdy_of(i) && k < 3000) begin @(negedge clk); k++; end
    drive(i, 1'b1, w1);
    prev = 1'b1;
    for (int n = 0; n < 1200; n++) begin
      @(negedge clk);
      if (prev && !rdy_of(i)) begin
        if (at1 < 0) begin at1 = n; drive(i, 1'b1, w2); end
        else begin at2 = n; drive(i, 1'b0, w2); break; end
      end
      prev = rdy_of(i);
    end
    if (at2 < 0) begin drive(i, 1'b0, w2); fail_now("b2b_second_accept"); end
    else per = at2 - at1;
  endtask

  function automatic logic [79:0] exp_of(logic [63:0] w);
    logic [79:0] e;
    for (int b = 0; b < 10; b++) e[79-8*b -: 8] = frame_byte(w, b);
    return e;
  endfunction

  int da, ra, per;
  logic [63:0] rw;

  initial begin
    @(posedge clk); #1;
    chk("reset_txb", txb_a, 1'b1);
    chk("reset_rdy", rdy_a, 1'b0);
    chk("reset_done", done_a, 1'b0);
    @(negedge clk);
    rst_a = 1'b0; rst_b = 1'b0;
    @(posedge clk); #1;
    chk("rdy_first_edge_a", rdy_a, 1'b1);
    chk("rdy_first_edge_b", rdy_b, 1'b1);

    run_frame(0, 64'h0123456789ABCDEF, 80'hA5EFCDAB896745230100, -1, -1, da, ra);
    chk("basic_done_at", da, 400);
    chk("basic_ready_at", ra, 408);

    run_frame(0, 64'h00000000000000FF, 80'hA5FF00000000000000FF, -1, -1, da, ra);

    b2b(0, 64'hDEADBEEFCAFEF00D, 64'h0F1E2D3C4B5A6978, per);
    chk("b2b_period_a", per, 409);

    run_frame(0, 64'h1122334455667788, 80'hA5887766554433221188, 150, -1, da, ra);
    chk("ignored_valid_done_at", da, 400);
    repeat (20) begin @(negedge clk); chk("no_second_frame", rdy_a, 1'b1); end

    rw = {$urandom, $urandom};
    run_frame(0, rw, exp_of(rw), -1, 150, da, ra);
    chk("rst_mid_no_done", da, -1);
    run_frame(0, 64'h1122334455667788, 80'hA5887766554433221188, -1, -1, da, ra);

    for (int r = 0; r < 5; r++) begin
      repeat ($urandom_range(0, 5)) @(negedge clk);
      rw = {$urandom, $urandom};
      run_frame(0, rw, exp_of(rw), -1, -1, da, ra);
    end

    run_frame(1, 64'h0123456789ABCDEF, 80'hA5EFCDAB896745230100, -1, -1, da, ra);
    chk("zero_gap_done_at", da, 200);
    chk("zero_gap_ready_at", ra, 200);
    b2b(1, {$urandom, $urandom}, {$urandom, $urandom}, per);
    chk("b2b_period_b", per, 201);

    repeat (450) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
